power_ctrl: RTL and testbench
=============================

# power_ctrl

Top-level power controller for the roach_monitor power manager. It arbitrates power requests from the register bus, the chassis power button and the fault monitor into single-cycle `power_up` / `power_down` commands for the rail sequencer. It tracks sequencer completion and enforces a cooldown between power cycles. After a fault it performs bounded automatic restarts, then latches a halt.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: stable cycles required before a button level is accepted (16-bit counter).
- `COOLDOWN_CYCLES`, default 1000000: minimum off time after `power_down_done` (32-bit).
- `START_TIMEOUT`, default 200000: maximum cycles from `power_up` to `power_up_done` (32-bit).
- `MAX_RETRIES`, default 3: automatic restarts allowed after faults (2-bit).
- `AUTO_RESTART`, default 1: 1 enables automatic restart after a fault.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sys_power_up` in 1: single-cycle request from the register bus.
- `sys_power_down` in 1: single-cycle request from the register bus.
- `chs_button` in 1: raw, asynchronous chassis button; 1 = pressed.
- `fault` in 1: level from the voltage/temperature monitor.
- `fault_clear` in 1: single-cycle request from the register bus.
- `power_up_done` in 1: sequencer status.
- `power_down_done` in 1: sequencer status.
- `power_up` out 1: single-cycle command to the sequencer.
- `power_down` out 1: single-cycle command to the sequencer.
- `ctrl_state` out 3: current state encoding.
- `fault_latched` out 1: a fault has occurred and has not been cleared.
- `retry_count` out 2: restarts used since the last clear.
- `pending_up` out 1: an up request is queued behind cooldown.

## Operation
- **Reset values.** All outputs are 0; `ctrl_state` = OFF. Timers, debounce counter, `pending_up`, `fault_latched` and `retry_count` are all 0.
- **Button path.**
  - 2-flop synchronizer, then the debounce counter.
  - A rising edge of the debounced level produces `btn_evt`.
  - In OFF or COOLDOWN, `btn_evt` is an up request. In STARTING or ON, it is a down request.
- **Priority within a cycle:** fault > down request > up request. `sys_power_up` together with `sys_power_down` resolves to down.
- **States and transitions:**
  - **OFF**
    - An up request with `fault` = 0 issues `power_up` and goes to STARTING.
    - An up request with `fault` = 1 is dropped.
  - **STARTING**
    - `power_up_done` → ON.
    - `fault`, or the `START_TIMEOUT` expiry → issue `power_down`, set `fault_latched`, go to STOPPING.
    - Down request → issue `power_down`, go to STOPPING.
  - **ON**
    - `fault` → issue `power_down`, set `fault_latched`, go to STOPPING.
    - Down request → issue `power_down`, go to STOPPING.
  - **STOPPING**
    - `power_down_done` → load the cooldown timer with `COOLDOWN_CYCLES`, go to COOLDOWN.
    - All requests are ignored.
  - **COOLDOWN**
    - An up request sets `pending_up`. A down request clears it.
    - At timer 0, evaluate in this order:
      1. `fault_latched` && `AUTO_RESTART` && `retry_count` < `MAX_RETRIES` && !`fault` → increment `retry_count`, issue `power_up`, go to STARTING.
      2. `fault_latched` && (`retry_count` == `MAX_RETRIES` || !`AUTO_RESTART`) → HALT.
      3. `pending_up` && !`fault` → issue `power_up`, go to STARTING.
      4. Otherwise → OFF.
    - `pending_up` is cleared on leaving COOLDOWN.
  - **HALT**
    - All power requests are ignored.
    - `fault_clear` with `fault` = 0 → clear `fault_latched` and `retry_count`, go to OFF.
- **`fault_clear` outside HALT:** clears `fault_latched` and `retry_count` only when `fault` = 0. Otherwise it has no effect.
- **`retry_count`** saturates at `MAX_RETRIES`.

## Timing
- **Command latency.** `power_up` / `power_down` are registered. They are high for exactly one cycle, the cycle after the triggering input is sampled. The state change happens on the same edge.
- **Done-input guard.** `power_up_done` and `power_down_done` are ignored for the first 2 cycles after any command is issued. This covers the sequencer's one-cycle state update.
- **Button latency.** `btn_evt` occurs 2 + `DEBOUNCE_CYCLES` cycles after a clean press. Glitches shorter than `DEBOUNCE_CYCLES` produce no event.
- **Timer counts.** The cooldown and start timers count down and reach 0 exactly `COOLDOWN_CYCLES` / `START_TIMEOUT` cycles after load.
- **Reset mid-operation.** Asserting `reset_n` low forces OFF asynchronously, including mid-STARTING or mid-COOLDOWN. No command is issued on release.
- **Fault in the command cycle.** A fault arriving in the same cycle a `power_up` is issued is handled on the next cycle from STARTING.

## Structure
- **Package `power_mgr_pkg`:** state encoding (OFF=0, STARTING=1, ON=2, STOPPING=3, COOLDOWN=4, HALT=5) and the default timing constants.
- **Sub-module `button_debounce`:** synchronizer, debounce counter and rising-edge detect. Parameter `DEBOUNCE_CYCLES`; output `btn_evt`.
- **Top level:** the FSM, both timers, and the retry/fault latches.

## Test plan
- **Normal cycle.** `sys_power_up` pulse → `power_up` one cycle later → model sequencer `power_up_done` → `ctrl_state` = 2. Then `sys_power_down` → `power_down` → `power_down_done` → COOLDOWN for 1000000 cycles → OFF.
- **Button.** 10-cycle glitch → no event. Press held 50002 cycles in OFF → `power_up`. Second press in ON → `power_down`.
- **Fault retries.**
  - `fault` pulse in ON → `power_down`, `fault_latched` = 1.
  - After cooldown (`fault` low) → `power_up`, `retry_count` = 1.
  - Repeat until the 4th fault → HALT.
  - `fault_clear` → OFF with `retry_count` = 0.
- **Start timeout.** Hold `power_up_done` low for 200000 cycles → `power_down`, `fault_latched` = 1, STOPPING.
- **Simultaneous and pending requests.**
  - `sys_power_up` and `sys_power_down` in the same cycle in ON → `power_down` only.
  - `sys_power_up` during COOLDOWN → `pending_up` = 1 → `power_up` at cooldown end.
- **Async reset.** `reset_n` low during STARTING → all outputs 0 immediately. After release, no command is issued.

Source files
------------

// File: rtl/power_mgr_pkg.sv
// Shared definitions for the roach_monitor power manager.
// Holds the controller state encoding (visible on ctrl_state) and the
// default timing constants used by power_ctrl and button_debounce.
package power_mgr_pkg;

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_STARTING = 3'd1,
      ST_ON       = 3'd2,
      ST_STOPPING = 3'd3,
      ST_COOLDOWN = 3'd4,
      ST_HALT     = 3'd5
   } ctrl_state_e;

   localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
   localparam logic [31:0] DEF_COOLDOWN_CYCLES = 32'd1000000;
   localparam logic [31:0] DEF_START_TIMEOUT   = 32'd200000;
   localparam logic [1:0]  DEF_MAX_RETRIES     = 2'd3;
   localparam logic        DEF_AUTO_RESTART    = 1'b1;

   // Sequencer done inputs are ignored for this many cycles after a command,
   // because the sequencer needs one cycle to update its own status.
   localparam logic [1:0]  DONE_GUARD_CYCLES   = 2'd2;

endpackage

// File: rtl/button_debounce.sv
// Chassis button conditioner.
// Synchronises the raw button into clk, accepts a new level only after it
// has been stable for DEBOUNCE_CYCLES cycles, and pulses btn_evt for one
// cycle when the accepted level rises (press).
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   chs_button in  raw asynchronous button, 1 = pressed
//   btn_evt    out one-cycle registered press event
module button_debounce
   import power_mgr_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk,
   input  logic reset_n,
   input  logic chs_button,
   output logic btn_evt
);

   logic        sync1_r;
   logic        sync2_r;
   logic        level_r;
   logic        evt_r;
   logic [15:0] cnt_r;

   // two-flop synchronizer for the asynchronous button input
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= chs_button;
         sync2_r <= sync2_r ^ (sync1_r ^ sync2_r);
      end
   end

   // stability counter: any return to the accepted level restarts the count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= 16'd0;
         level_r <= 1'b0;
         evt_r   <= 1'b0;
      end else if (sync2_r == level_r) begin
         cnt_r   <= 16'd0;
         evt_r   <= 1'b0;
      end else if (cnt_r >= (DEBOUNCE_CYCLES - 16'd1)) begin
         cnt_r   <= 16'd0;
         level_r <= sync2_r;
         evt_r   <= sync2_r;
      end else begin
         cnt_r   <= cnt_r + 16'd1;
         evt_r   <= 1'b0;
      end
   end

   assign btn_evt = evt_r;

endmodule

// File: rtl/power_ctrl.sv
// Top-level power controller.
// Arbitrates register-bus, chassis-button and fault requests into
// single-cycle power_up / power_down commands for the rail sequencer,
// enforces a cooldown after every power-down, and performs bounded
// automatic restarts after faults before latching HALT.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   sys_power_up, sys_power_down       one-cycle register-bus requests
//   chs_button                         raw chassis button (1 = pressed)
//   fault                              monitor fault level
//   fault_clear                        one-cycle register-bus clear
//   power_up_done, power_down_done     sequencer status
//   power_up, power_down               one-cycle registered commands
//   ctrl_state                         current state (power_mgr_pkg encoding)
//   fault_latched, retry_count         fault history since last clear
//   pending_up                         up request queued behind cooldown
module power_ctrl
   import power_mgr_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [31:0] COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter logic [31:0] START_TIMEOUT   = DEF_START_TIMEOUT,
   parameter logic [1:0]  MAX_RETRIES     = DEF_MAX_RETRIES,
   parameter logic        AUTO_RESTART    = DEF_AUTO_RESTART
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sys_power_up,
   input  logic       sys_power_down,
   input  logic       chs_button,
   input  logic       fault,
   input  logic       fault_clear,
   input  logic       power_up_done,
   input  logic       power_down_done,
   output logic       power_up,
   output logic       power_down,
   output logic [2:0] ctrl_state,
   output logic       fault_latched,
   output logic [1:0] retry_count,
   output logic       pending_up
);

   ctrl_state_e state_r, state_nxt_s;
   logic        btn_evt_s, up_req_s, down_req_s, done_ok_s, clear_ok_s;
   logic        power_up_r, power_down_r, up_nxt_s, down_nxt_s;
   logic        latched_r, latched_nxt_s;
   logic [1:0]  retry_r, retry_nxt_s;
   logic        pending_r, pending_nxt_s, pend_eff_s;
   logic        start_ld_s, cool_ld_s;
   logic [31:0] start_tmr_r, cool_tmr_r;
   logic [1:0]  guard_r;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button_debounce (
      .clk        (clk),
      .reset_n    (reset_n),
      .chs_button (chs_button),
      .btn_evt    (btn_evt_s)
   );

   // The button toggles: it asks for power when off, for shutdown when on.
   assign up_req_s   = sys_power_up |
                       (btn_evt_s & ((state_r == ST_OFF) | (state_r == ST_COOLDOWN)));
   assign down_req_s = sys_power_down |
                       (btn_evt_s & ((state_r == ST_STARTING) | (state_r == ST_ON)));
   assign done_ok_s  = (guard_r == 2'd0);
   assign clear_ok_s = fault_clear & ~fault;

   // next-state, command and fault-history decode
   always_comb begin
      state_nxt_s   = state_r;
      up_nxt_s      = 1'b0;
      down_nxt_s    = 1'b0;
      start_ld_s    = 1'b0;
      cool_ld_s     = 1'b0;
      pend_eff_s    = 1'b0;
      pending_nxt_s = 1'b0;
      if (clear_ok_s) begin
         latched_nxt_s = 1'b0;
         retry_nxt_s   = 2'd0;
      end else begin
         latched_nxt_s = latched_r;
         retry_nxt_s   = retry_r;
      end
      case (state_r)
         ST_OFF: begin
            // a simultaneous down request wins and is a no-op here
            if (up_req_s && !down_req_s && !fault) begin
               up_nxt_s    = 1'b1;
               start_ld_s  = 1'b1;
               state_nxt_s = ST_STARTING;
            end else begin
               state_nxt_s = ST_OFF;
            end
         end
         ST_STARTING: begin
            if (fault || (start_tmr_r == 32'd0)) begin
               down_nxt_s    = 1'b1;
               latched_nxt_s = 1'b1;
               state_nxt_s   = ST_STOPPING;
            end else if (down_req_s) begin
               down_nxt_s    = 1'b1;
               state_nxt_s   = ST_STOPPING;
            end else if (done_ok_s && power_up_done) begin
               state_nxt_s   = ST_ON;
            end else begin
               state_nxt_s   = ST_STARTING;
            end
         end
         ST_ON: begin
            if (fault) begin
               down_nxt_s    = 1'b1;
               latched_nxt_s = 1'b1;
               state_nxt_s   = ST_STOPPING;
            end else if (down_req_s) begin
               down_nxt_s    = 1'b1;
               state_nxt_s   = ST_STOPPING;
            end else begin
               state_nxt_s   = ST_ON;
            end
         end
         ST_STOPPING: begin
            if (done_ok_s && power_down_done) begin
               cool_ld_s   = 1'b1;
               state_nxt_s = ST_COOLDOWN;
            end else begin
               state_nxt_s = ST_STOPPING;
            end
         end
         ST_COOLDOWN: begin
            if (down_req_s) begin
               pend_eff_s = 1'b0;
            end else if (up_req_s) begin
               pend_eff_s = 1'b1;
            end else begin
               pend_eff_s = pending_r;
            end
            // decisions use the post-clear fault history of this cycle
            if (cool_tmr_r != 32'd0) begin
               pending_nxt_s = pend_eff_s;
            end else if (latched_nxt_s && AUTO_RESTART &&
                         (retry_nxt_s < MAX_RETRIES) && !fault) begin
               retry_nxt_s = retry_nxt_s + 2'd1;
               up_nxt_s    = 1'b1;
               start_ld_s  = 1'b1;
               state_nxt_s = ST_STARTING;
            end else if (latched_nxt_s &&
                         ((retry_nxt_s == MAX_RETRIES) || !AUTO_RESTART)) begin
               state_nxt_s = ST_HALT;
            end else if (pend_eff_s && !fault) begin
               up_nxt_s    = 1'b1;
               start_ld_s  = 1'b1;
               state_nxt_s = ST_STARTING;
            end else begin
               state_nxt_s = ST_OFF;
            end
         end
         ST_HALT: begin
            if (clear_ok_s) begin
               state_nxt_s = ST_OFF;
            end else begin
               state_nxt_s = ST_HALT;
            end
         end
         default: begin
            state_nxt_s = ST_OFF;
         end
      endcase
   end

   // state, registered commands and fault history
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_OFF;
         power_up_r   <= 1'b0;
         power_down_r <= 1'b0;
         latched_r    <= 1'b0;
         retry_r      <= 2'd0;
         pending_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         power_up_r   <= up_nxt_s;
         power_down_r <= down_nxt_s;
         latched_r    <= latched_nxt_s;
         retry_r      <= retry_nxt_s;
         pending_r    <= pending_nxt_s;
      end
   end

   // start timeout, cooldown timer and done-input guard
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_tmr_r <= 32'd0;
         cool_tmr_r  <= 32'd0;
         guard_r     <= 2'd0;
      end else begin
         if (start_ld_s) begin
            start_tmr_r <= START_TIMEOUT;
         end else if ((state_r == ST_STARTING) && (start_tmr_r != 32'd0)) begin
            start_tmr_r <= start_tmr_r - 32'd1;
         end else begin
            start_tmr_r <= start_tmr_r;
         end
         if (cool_ld_s) begin
            cool_tmr_r <= COOLDOWN_CYCLES;
         end else if ((state_r == ST_COOLDOWN) && (cool_tmr_r != 32'd0)) begin
            cool_tmr_r <= cool_tmr_r - 32'd1;
         end else begin
            cool_tmr_r <= cool_tmr_r;
         end
         if (up_nxt_s || down_nxt_s) begin
            guard_r <= DONE_GUARD_CYCLES;
         end else if (guard_r != 2'd0) begin
            guard_r <= guard_r - 2'd1;
         end else begin
            guard_r <= guard_r;
         end
      end
   end

   assign power_up      = power_up_r;
   assign power_down    = power_down_r;
   assign ctrl_state    = state_r;
   assign fault_latched = latched_r;
   assign retry_count   = retry_r;
   assign pending_up    = pending_r;

endmodule

// File: tb/tb_power_ctrl.sv
// Self-checking bench for power_ctrl with shortened timing parameters.
// Expected commands are queued by the stimulus; a monitor pops and checks
// them whenever the DUT raises power_up or power_down.
module tb_power_ctrl;
   import power_mgr_pkg::*;

   localparam int DEB  = 20;
   localparam int COOL = 50;
   localparam int STO  = 100;

   localparam logic [1:0] CMD_UP = 2'b10;
   localparam logic [1:0] CMD_DN = 2'b01;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sys_power_up = 1'b0, sys_power_down = 1'b0, chs_button = 1'b0;
   logic       fault = 1'b0, fault_clear = 1'b0;
   logic       power_up_done = 1'b0, power_down_done = 1'b0;
   logic       power_up, power_down, fault_latched, pending_up;
   logic [2:0] ctrl_state;
   logic [1:0] retry_count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0] cmd;
      logic [2:0] st;
      logic       lat;
      logic [1:0] rty;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   power_ctrl #(
      .DEBOUNCE_CYCLES(16'd20), .COOLDOWN_CYCLES(32'd50), .START_TIMEOUT(32'd100),
      .MAX_RETRIES(2'd3), .AUTO_RESTART(1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sys_power_up(sys_power_up),
      .sys_power_down(sys_power_down), .chs_button(chs_button), .fault(fault),
      .fault_clear(fault_clear), .power_up_done(power_up_done),
      .power_down_done(power_down_done), .power_up(power_up), .power_down(power_down),
      .ctrl_state(ctrl_state), .fault_latched(fault_latched),
      .retry_count(retry_count), .pending_up(pending_up)
   );

   always #5 clk = ~clk;

   // monitor: every command the DUT issues must match the queued expectation
   always @(negedge clk) begin
      if (reset_n && (power_up || power_down)) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cmd: got up=%0b down=%0b state=%0d, required no command",
                     power_up, power_down, ctrl_state);
         end else begin
            mon_e = exp_q.pop_front();
            if ({power_up, power_down} !== mon_e.cmd || ctrl_state !== mon_e.st ||
                fault_latched !== mon_e.lat || retry_count !== mon_e.rty) begin
               bad++;
               $display("FAIL cmd_check: got cmd=%b state=%0d lat=%0b retry=%0d, required cmd=%b state=%0d lat=%0b retry=%0d",
                        {power_up, power_down}, ctrl_state, fault_latched, retry_count,
                        mon_e.cmd, mon_e.st, mon_e.lat, mon_e.rty);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic expect_cmd(input logic [1:0] cmd, input logic [2:0] st,
                             input logic lat, input logic [1:0] rty);
      exp_t e;
      e.cmd = cmd; e.st = st; e.lat = lat; e.rty = rty;
      exp_q.push_back(e);
   endtask

   // waits (bounded) for ctrl_state == s; n = negedges waited
   task automatic wait_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ctrl_state !== s && n < budget);
      check("wait_state", ctrl_state, s);
   endtask

   task automatic pulse(input int which);
      @(posedge clk); #1;
      case (which)
         0: sys_power_up = 1'b1;
         1: sys_power_down = 1'b1;
         2: fault = 1'b1;
         3: fault_clear = 1'b1;
         4: begin sys_power_up = 1'b1; sys_power_down = 1'b1; end
         default: ;
      endcase
      @(posedge clk); #1;
      sys_power_up = 1'b0; sys_power_down = 1'b0; fault = 1'b0; fault_clear = 1'b0;
   endtask

   // sequencer model: answer after the done-input guard has expired
   task automatic seq_done(input logic up);
      repeat (3) @(posedge clk);
      #1;
      if (up) power_up_done = 1'b1; else power_down_done = 1'b1;
      @(posedge clk); #1;
      power_up_done = 1'b0; power_down_done = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_power_up"}, power_up, 0);
      check({tag, "_power_down"}, power_down, 0);
      check({tag, "_state"}, ctrl_state, ST_OFF);
      check({tag, "_latched"}, fault_latched, 0);
      check({tag, "_retry"}, retry_count, 0);
      check({tag, "_pending"}, pending_up, 0);
   endtask

   initial begin
      int n;
      // reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 reset_n = 1'b1;

      // normal cycle with done-guard boundary
      expect_cmd(CMD_UP, ST_STARTING, 1'b0, 2'd0);
      pulse(0);
      wait_state(ST_STARTING, 5, n);
      @(posedge clk); #1 power_up_done = 1'b1;   // sampled while guarded
      @(posedge clk); #1 power_up_done = 1'b0;
      @(negedge clk);
      check("done_guard", ctrl_state, ST_STARTING);
      seq_done(1'b1);
      wait_state(ST_ON, 5, n);
      expect_cmd(CMD_DN, ST_STOPPING, 1'b0, 2'd0);
      pulse(1);
      wait_state(ST_STOPPING, 5, n);
      seq_done(1'b0);
      wait_state(ST_COOLDOWN, 5, n);
      wait_state(ST_OFF, COOL + 10, n);
      check("cooldown_len", n, COOL + 1);

      // pending up during cooldown
      expect_cmd(CMD_UP, ST_STARTING, 1'b0, 2'd0);
      pulse(0);
      wait_state(ST_STARTING, 5, n);
      seq_done(1'b1);
      wait_state(ST_ON, 5, n);
      expect_cmd(CMD_DN, ST_STOPPING, 1'b0, 2'd0);
      pulse(1);
      wait_state(ST_STOPPING, 5, n);
      seq_done(1'b0);
      wait_state(ST_COOLDOWN, 5, n);
      pulse(0);
      @(negedge clk);
      check("pending_set", pending_up, 1);
      expect_cmd(CMD_UP, ST_STARTING, 1'b0, 2'd0);
      wait_state(ST_STARTING, COOL + 10, n);
      check("pending_cleared", pending_up, 0);
      seq_done(1'b1);
      wait_state(ST_ON, 5, n);

      // simultaneous up+down in ON resolves to down only
      expect_cmd(CMD_DN, ST_STOPPING, 1'b0, 2'd0);
      pulse(4);
      wait_state(ST_STOPPING, 5, n);
      seq_done(1'b0);
      wait_state(ST_COOLDOWN, 5, n);
      wait_state(ST_OFF, COOL + 10, n);

      // up request in OFF while fault is high is dropped
      fault = 1'b1;
      pulse(0);
      fault = 1'b1;
      repeat (3) @(negedge clk);
      check("fault_blocks_up", ctrl_state, ST_OFF);
      fault = 1'b0;

      // button: short glitch, then clean presses
      @(posedge clk); #1 chs_button = 1'b1;
      repeat (10) @(posedge clk);
      #1 chs_button = 1'b0;
      repeat (DEB + 20) @(negedge clk);
      check("glitch_ignored", ctrl_state, ST_OFF);
      expect_cmd(CMD_UP, ST_STARTING, 1'b0, 2'd0);
      @(posedge clk); #1 chs_button = 1'b1;
      wait_state(ST_STARTING, DEB + 10, n);
      check("button_latency", n, DEB + 4);
      #1 chs_button = 1'b0;
      repeat (DEB + 5) @(posedge clk);
      seq_done(1'b1);
      wait_state(ST_ON, 5, n);
      expect_cmd(CMD_DN, ST_STOPPING, 1'b0, 2'd0);
      @(posedge clk); #1 chs_button = 1'b1;
      wait_state(ST_STOPPING, DEB + 10, n);
      #1 chs_button = 1'b0;
      repeat (DEB + 5) @(posedge clk);
      seq_done(1'b0);
      wait_state(ST_COOLDOWN, 5, n);
      wait_state(ST_OFF, COOL + 10, n);

      // fault retries up to HALT
      expect_cmd(CMD_UP, ST_STARTING, 1'b0, 2'd0);
      pulse(0);
      wait_state(ST_STARTING, 5, n);
      seq_done(1'b1);
      wait_state(ST_ON, 5, n);
      for (int i = 0; i < 4; i++) begin
         expect_cmd(CMD_DN, ST_STOPPING, 1'b1, 2'(i));
         pulse(2);
         wait_state(ST_STOPPING, 5, n);
         seq_done(1'b0);
         wait_state(ST_COOLDOWN, 5, n);
         if (i < 3) begin
            expect_cmd(CMD_UP, ST_STARTING, 1'b1, 2'(i + 1));
            wait_state(ST_STARTING, COOL + 10, n);
            seq_done(1'b1);
            wait_state(ST_ON, 5, n);
         end else begin
            wait_state(ST_HALT, COOL + 10, n);
         end
      end
      check("halt_latched", fault_latched, 1);
      check("halt_retry", retry_count, 3);
      pulse(0);
      repeat (3) @(negedge clk);
      check("halt_ignores_up", ctrl_state, ST_HALT);
      pulse(3);
      wait_state(ST_OFF, 5, n);
      check("clear_retry", retry_count, 0);
      check("clear_latched", fault_latched, 0);

      // start timeout
      expect_cmd(CMD_UP, ST_STARTING, 1'b0, 2'd0);
      pulse(0);
      wait_state(ST_STARTING, 5, n);
      expect_cmd(CMD_DN, ST_STOPPING, 1'b1, 2'd0);
      wait_state(ST_STOPPING, STO + 10, n);
      check("timeout_len", n, STO + 1);
      check("timeout_latched", fault_latched, 1);
      seq_done(1'b0);
      wait_state(ST_COOLDOWN, 5, n);
      expect_cmd(CMD_UP, ST_STARTING, 1'b1, 2'd1);
      wait_state(ST_STARTING, COOL + 10, n);
      pulse(3);
      @(negedge clk);
      check("clear_outside_halt_lat", fault_latched, 0);
      check("clear_outside_halt_rty", retry_count, 0);

      // asynchronous reset in STARTING
      check("pre_reset_state", ctrl_state, ST_STARTING);
      @(posedge clk); #3 reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("after_reset_state", ctrl_state, ST_OFF);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
